// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: FSM state encoding and
// the step-counter width derived from the operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Start/busy/done handshake and operand/result bus between the decode path
// (master) and the divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, sign, dividend, divisor,
    input  q, r, busy, done, dz
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output q, r, busy, done, dz
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into
// the partial remainder and subtracts the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Compare rather than test the borrow bit: with a zero divisor the shifted
  // value can exceed 2^WIDTH and the subtraction would look negative.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, dvs};
    q_bit   = (shifted >= {1'b0, dvs});
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (IDLE -> CALC x WIDTH -> FIX), WIDTH+1 cycle latency.
// Signed mode is compiled in only when DIV_SIGNED_EN is defined.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      reset_n,
  div_unit_if.slave dif
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic dvd_neg;
  logic dvs_neg;

  assign dvd_neg = dif.sign & dif.dividend[WIDTH-1];
  assign dvs_neg = dif.sign & dif.divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dif.dividend : dif.dividend;
  assign dvs_mag = dvs_neg ? -dif.divisor : dif.divisor;
`else
  logic sign_unused;

  assign sign_unused = dif.sign;
  assign dvd_mag     = dif.dividend;
  assign dvs_mag     = dif.divisor;
`endif

  // The dividend shift register doubles as the quotient register: each step
  // consumes its MSB and appends the new quotient bit at the LSB.
  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[WIDTH-1]),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    zero_d    = zero_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (dif.start) begin
          rem_d     = '0;
          quo_d     = dvd_mag;
          dvs_d     = dvs_mag;
          zero_d    = (dif.divisor == '0);
          cnt_d     = CW'(WIDTH);
          state_d   = CALC;
`ifdef DIV_SIGNED_EN
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
`endif
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
`ifdef DIV_SIGNED_EN
        q_d = neg_quo_q ? -quo_q : quo_q;
        r_d = neg_rem_q ? -rem_q : rem_q;
`else
        q_d = quo_q;
        r_d = rem_q;
`endif
        // A zero divisor leaves |dividend| in the remainder, which the sign
        // fix turns back into the dividend as supplied; only q needs forcing.
        if (zero_q) begin
          q_d = '1;
        end
        dz_d    = zero_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      zero_q    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      zero_q    <= zero_d;
      q_q       <= q_d;
      r_q       <= r_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign dif.q    = q_q;
  assign dif.r    = r_q;
  assign dif.dz   = dz_q;
  assign dif.done = done_q;
  assign dif.busy = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (WIDTH=32): arithmetic reference model with a
// per-cycle compare, directed literal cases and randomized operations.
module tb_div_unit;

  localparam int W = 32;

`ifdef DIV_SIGNED_EN
  localparam bit          SIGNED_EN = 1'b1;
  localparam logic [31:0] E_M7_Q    = 32'hFFFF_FFFD;
  localparam logic [31:0] E_M7_R    = 32'hFFFF_FFFF;
  localparam logic [31:0] E_P7_Q    = 32'hFFFF_FFFD;
  localparam logic [31:0] E_P7_R    = 32'h0000_0001;
  localparam logic [31:0] E_MN_Q    = 32'h8000_0000;
  localparam logic [31:0] E_MN_R    = 32'h0000_0000;
`else
  localparam bit          SIGNED_EN = 1'b0;
  localparam logic [31:0] E_M7_Q    = 32'h7FFF_FFFC;
  localparam logic [31:0] E_M7_R    = 32'h0000_0001;
  localparam logic [31:0] E_P7_Q    = 32'h0000_0000;
  localparam logic [31:0] E_P7_R    = 32'h0000_0007;
  localparam logic [31:0] E_MN_Q    = 32'h0000_0000;
  localparam logic [31:0] E_MN_R    = 32'h8000_0000;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  div_unit_if #(.WIDTH(W)) dif ();

  div_unit #(
    .WIDTH (W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dif     (dif)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic. SV '/' and '%' on signed values truncate toward zero.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    longint sa;
    longint sb;
    dz = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s && SIGNED_EN) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  logic [W-1:0] exp_q, exp_r, pend_q, pend_r;
  logic         exp_busy, exp_done, exp_dz, pend_dz;
  int           left;
  bit           model_live = 1'b0;

  // Transaction-level model: an accepted start yields its result WIDTH+1 edges later.
  always @(posedge clock) begin
    if (!reset_n) begin
      exp_q = '0; exp_r = '0; exp_dz = 1'b0;
      exp_busy = 1'b0; exp_done = 1'b0; left = 0;
      model_live = 1'b1;
    end else begin
      exp_done = 1'b0;
      if (exp_busy) begin
        left--;
        if (left == 0) begin
          exp_busy = 1'b0;
          exp_done = 1'b1;
          exp_q    = pend_q;
          exp_r    = pend_r;
          exp_dz   = pend_dz;
        end
      end else if (dif.start) begin
        ref_div(dif.sign, dif.dividend, dif.divisor, pend_q, pend_r, pend_dz);
        exp_busy = 1'b1;
        left     = W + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (model_live) begin
      check("busy", W'(dif.busy), W'(exp_busy));
      check("done", W'(dif.done), W'(exp_done));
      check("q",    dif.q,        exp_q);
      check("r",    dif.r,        exp_r);
      check("dz",   W'(dif.dz),   W'(exp_dz));
    end
  end

  // Called at a negedge; issues one operation and waits for its done pulse.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject_at, input int reset_at,
                        output bit got, output int lat, output int busy_cnt,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    dif.start    = 1'b1;
    dif.sign     = s;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clock);
    got = 1'b0; lat = 0; busy_cnt = 0; q = '0; r = '0; dz = 1'b0;
    for (int j = 0; j < 60 && !got; j++) begin
      @(negedge clock);
      dif.start    = 1'b0;
      dif.sign     = 1'($urandom);
      dif.dividend = $urandom;
      dif.divisor  = $urandom;
      if (j == inject_at) begin
        dif.start    = 1'b1;
        dif.dividend = 32'h0000_0063;
        dif.divisor  = 32'h0000_0007;
      end
      if (reset_at >= 0 && j == reset_at + 1) begin
        check("rst_q",    dif.q, '0);
        check("rst_r",    dif.r, '0);
        check("rst_busy", W'(dif.busy), '0);
        check("rst_done", W'(dif.done), '0);
        check("rst_dz",   W'(dif.dz), '0);
        reset_n = 1'b1;
      end
      if (j == reset_at) reset_n = 1'b0;
      if (dif.busy) busy_cnt++;
      if (dif.done) begin
        got = 1'b1;
        q   = dif.q;
        r   = dif.r;
        dz  = dif.dz;
      end else begin
        lat++;
      end
    end
    $display("op sign=%0d %h / %h -> done=%0d q=%h r=%h dz=%0d lat=%0d busy=%0d",
             s, a, b, got, q, r, dz, lat, busy_cnt);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit           got;
    int           lat, bcnt;
    logic [W-1:0] q, r;
    logic         dz;

    dif.start = 1'b0; dif.sign = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(negedge clock);
    check("reset_q",    dif.q, '0);
    check("reset_busy", W'(dif.busy), '0);
    check("reset_done", W'(dif.done), '0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(1'b0, 32'h0000_000A, 32'h0000_0002, -1, -1, got, lat, bcnt, q, r, dz);
    check("u10_got", W'(got), 1); check("u10_q", q, 5); check("u10_r", r, 0);
    check("u10_dz", W'(dz), 0); check("u10_lat", W'(lat), 33); check("u10_busy", W'(bcnt), 33);

    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1, got, lat, bcnt, q, r, dz);
    check("m7_q", q, E_M7_Q); check("m7_r", r, E_M7_R);

    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, -1, -1, got, lat, bcnt, q, r, dz);
    check("p7_q", q, E_P7_Q); check("p7_r", r, E_P7_R);

    for (int s = 0; s < 2; s++) begin
      run_op(1'(s), 32'h0000_1234, 32'h0, -1, -1, got, lat, bcnt, q, r, dz);
      check("dz_q", q, 32'hFFFF_FFFF); check("dz_r", r, 32'h0000_1234);
      check("dz_flag", W'(dz), 1); check("dz_lat", W'(lat), 33);
    end

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, got, lat, bcnt, q, r, dz);
    check("mn_q", q, E_MN_Q); check("mn_r", r, E_MN_R); check("mn_dz", W'(dz), 0);

    run_op(1'b0, 32'h0000_000A, 32'h0000_0002, 5, -1, got, lat, bcnt, q, r, dz);
    check("inj_q", q, 5); check("inj_r", r, 0); check("inj_lat", W'(lat), 33);

    run_op(1'b0, 32'hFFFF_0000, 32'h0000_0003, -1, 10, got, lat, bcnt, q, r, dz);
    check("rst_nodone", W'(got), 0);

    run_op(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, -1, -1, got, lat, bcnt, q, r, dz);
    check("aa_q", q, 2); check("aa_r", r, 0);

    // start coinciding with reset must not launch an operation
    dif.start = 1'b1; reset_n = 1'b0;
    @(negedge clock);
    check("rs_busy0", W'(dif.busy), 0);
    dif.start = 1'b0; reset_n = 1'b1;
    @(negedge clock);
    check("rs_busy1", W'(dif.busy), 0);

    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom), pick(), pick(), -1, -1, got, lat, bcnt, q, r, dz);
      check("rand_got", W'(got), 1);
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
